// File: rtl/msrv32_branch_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_branch_ctrl
//
// Turns a resolved control-transfer instruction into a redirect request to
// fetch. After fetch accepts the redirect, the block squashes younger
// in-flight instructions for a fixed number of flush cycles. A taken target
// that is not word aligned does not redirect. It raises a one-cycle
// misaligned pulse and captures the offending address instead. While a
// redirect or flush is in progress, any further resolves come from the wrong
// path and are ignored.
//
// Parameters
//   FLUSH_CYCLES        flush cycles after the redirect handshake (0..15)
//   RESET_PC            reset value of redirect_pc_out / misaligned_addr_out
//
// Ports
//   clk_in              clock, rising-edge
//   rst_in              synchronous active-high reset
//   resolve_valid_in    a control-transfer instruction resolves this cycle
//   branch_taken_in     taken flag from the branch unit
//   target_addr_in      computed branch / jump target
//   redirect_ready_in   fetch accepts the redirect
//   redirect_valid_out  redirect request to fetch
//   redirect_pc_out     registered redirect target
//   flush_out           squash younger in-flight instructions
//   stall_out           hold decode/issue while busy
//   misaligned_out      one-cycle pulse for a misaligned taken target
//   misaligned_addr_out offending target address
//
// Optional feature (macro BRANCH_CTRL_STATS_EN)
//   resolved_count_out  resolves accepted in IDLE (wraps at 2^32)
//   taken_count_out     accepted taken resolves, misaligned included
//
// The outputs come straight from registers or are decoded only from the
// state register. No input reaches an output combinationally.
// ---------------------------------------------------------------------------
module msrv32_branch_ctrl #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        resolve_valid_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        redirect_ready_in,
  output logic        redirect_valid_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out,
  output logic        stall_out,
  output logic        misaligned_out,
`ifdef BRANCH_CTRL_STATS_EN
  output logic [31:0] misaligned_addr_out,
  output logic [31:0] resolved_count_out,
  output logic [31:0] taken_count_out
`else
  output logic [31:0] misaligned_addr_out
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t     state;
  logic [3:0] flush_cnt;

  // A resolve counts only in IDLE. In the other states it is wrong-path.
  logic accept;
  logic accept_taken;
  logic target_misaligned;

  assign accept            = (state == IDLE) && resolve_valid_in;
  assign accept_taken      = accept && branch_taken_in;
  assign target_misaligned = (target_addr_in[1:0] != 2'b00);

  // Handshake signals are decoded from the state register only.
  assign redirect_valid_out = (state == REDIRECT);
  assign flush_out          = (state != IDLE);
  assign stall_out          = (state != IDLE);

  // NOTE: every register in this block uses non-blocking assignments. Each
  // flop therefore samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= IDLE;
      flush_cnt           <= '0;
      redirect_pc_out     <= RESET_PC;
      misaligned_out      <= 1'b0;
      misaligned_addr_out <= RESET_PC;
    end else begin
      // The pulse defaults low, so a misaligned target raises it for one cycle only.
      misaligned_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_taken) begin
            if (target_misaligned) begin
              misaligned_out      <= 1'b1;
              misaligned_addr_out <= target_addr_in;
            end else begin
              redirect_pc_out <= target_addr_in;
              state           <= REDIRECT;
            end
          end
        end
        REDIRECT: begin
          // redirect_pc_out holds its value until fetch accepts the redirect.
          if (redirect_ready_in) begin
            if (FLUSH_INIT == 4'd0) begin
              state <= IDLE;
            end else begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_INIT;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd1) begin
            state     <= IDLE;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          flush_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BRANCH_CTRL_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      resolved_count_out <= '0;
      taken_count_out    <= '0;
    end else begin
      // Plain 32-bit increments wrap from 32'hFFFF_FFFF to 0.
      if (accept)       resolved_count_out <= resolved_count_out + 32'd1;
      if (accept_taken) taken_count_out    <= taken_count_out + 32'd1;
    end
  end
`endif

endmodule

// File: doc/msrv32_branch_ctrl.md
MSRV32_BRANCH_CTRL -- requirements
Module: msrv32_branch_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of flush cycles after the redirect handshake (range 0-15).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, value of redirect_pc_out and misaligned_addr_out after reset.
REQ-003 SHALL have port clk_in, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port resolve_valid_in, input, 1, a control-transfer instruction is resolved this cycle.
REQ-006 SHALL have port branch_taken_in, input, 1, taken flag from the branch unit.
REQ-007 SHALL have port target_addr_in, input, 32, computed branch or jump target.
REQ-008 SHALL have port redirect_ready_in, input, 1, fetch accepts the redirect.
REQ-009 SHALL have port redirect_valid_out, output, 1, redirect request to fetch.
REQ-010 SHALL have port redirect_pc_out, output, 32, registered redirect target.
REQ-011 SHALL have port flush_out, output, 1, squash younger in-flight instructions.
REQ-012 SHALL have port stall_out, output, 1, hold decode/issue while the block is busy.
REQ-013 SHALL have port misaligned_out, output, 1, one-cycle pulse for a misaligned taken target.
REQ-014 SHALL have port misaligned_addr_out, output, 32, the offending target address.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, REDIRECT, FLUSH.
REQ-016 In IDLE, a cycle with resolve_valid_in=1, branch_taken_in=1 and target_addr_in[1:0]==2'b00 SHALL cause, on the next edge: state REDIRECT and redirect_pc_out=target_addr_in.
REQ-017 In IDLE, a resolve with branch_taken_in=0 SHALL take no action; the state stays IDLE.
REQ-018 In IDLE, a taken resolve with target_addr_in[1:0]!=2'b00 SHALL, on the next edge, pulse misaligned_out high for exactly one cycle and load misaligned_addr_out; no redirect, state stays IDLE.
REQ-019 In REDIRECT: redirect_valid_out=1, flush_out=1, stall_out=1; redirect_pc_out SHALL stay stable until the handshake.
REQ-020 Handshake SHALL complete on an edge where redirect_valid_out and redirect_ready_in are both 1.
REQ-021 On handshake, the next state SHALL be FLUSH with counter loaded to FLUSH_CYCLES, or IDLE directly if FLUSH_CYCLES==0.
REQ-022 In FLUSH: flush_out=1, stall_out=1, redirect_valid_out=0; the counter SHALL decrement each cycle and the state SHALL return to IDLE on the edge where the counter equals 1.
REQ-023 Total flush_out high time SHALL be (cycles spent in REDIRECT) + FLUSH_CYCLES.
REQ-024 Any resolve_valid_in seen in REDIRECT or FLUSH is wrong-path and SHALL be ignored: no state change, no misaligned pulse, no counting.
REQ-025 In IDLE, redirect_valid_out, flush_out and stall_out SHALL be 0, so a resolve is accepted on the first IDLE cycle after FLUSH.
REQ-026 All outputs SHALL be driven from registers or decoded only from the state register, with no combinational path from any input to any output.

Reset
REQ-027 rst_in=1 at an edge SHALL force state IDLE and counter 0 from any state, including mid-REDIRECT and mid-FLUSH, abandoning any pending redirect.
REQ-028 Reset values SHALL be: redirect_valid_out=0, flush_out=0, stall_out=0, misaligned_out=0, redirect_pc_out=RESET_PC, misaligned_addr_out=RESET_PC, statistics counters=0.
REQ-029 rst_in SHALL take priority over any simultaneous resolve or handshake.

Configuration
REQ-030 Macro BRANCH_CTRL_STATS_EN SHALL compile in outputs resolved_count_out[31:0] and taken_count_out[31:0].
REQ-031 With BRANCH_CTRL_STATS_EN defined: resolved_count_out SHALL increment on every resolve accepted in IDLE, and taken_count_out on every accepted taken resolve, including misaligned ones.
REQ-032 Both counters SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-033 Without BRANCH_CTRL_STATS_EN: the counter ports and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Taken, target 32'h0000_0100, redirect_ready_in=1, FLUSH_CYCLES=2 -> REDIRECT 1 cycle with redirect_pc_out=0x100, then FLUSH 2 cycles, flush_out high 3 cycles total, then IDLE.
REQ-035 Taken, target 0x200, redirect_ready_in held 0 for 4 cycles -> redirect_valid_out high 5 cycles, redirect_pc_out stable at 0x200 throughout, flush_out high 7 cycles total.
REQ-036 Taken, target 32'h0000_0102 -> misaligned_out high 1 cycle, misaligned_addr_out=0x102, redirect_valid_out stays 0.
REQ-037 New taken resolve (target 0x300) during FLUSH -> ignored; redirect_pc_out stays at the prior target; with stats enabled, counters unchanged.
REQ-038 rst_in asserted during REDIRECT with redirect_ready_in=0 -> all outputs at reset values on the next cycle; a taken resolve the cycle after reset releases is accepted.
REQ-039 With BRANCH_CTRL_STATS_EN, 3 not-taken plus 2 taken resolves -> resolved_count_out=5, taken_count_out=2; counter preloaded to 0xFFFF_FFFF wraps to 0.
